// File: rtl/psec_spi_regbank.sv
`default_nettype none
// psec_spi_regbank: SPI slave register bank (burst access, read-only status, instruction pulses). Rev 1.0
// Optional odd parity per data word when SPI_PARITY_EN is defined (adds parity_err port).
module psec_spi_regbank #(
  parameter int                           NUM_REGS  = 16,
  parameter int                           DATA_W    = 8,
  parameter int                           ADDR_W    = 7,
  parameter logic [NUM_REGS-1:0]          WR_MASK   = 16'hFFF7,
  parameter int                           INST_ADDR = 3,
  parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VAL = '0
) (
  input  logic                         spi_clk,
  input  logic                         rst,
  input  logic                         cs,
  input  logic                         pico,
  output logic                         poci,
  input  logic [NUM_REGS*DATA_W-1:0]   status_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [DATA_W-1:0]            inst_pulse,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr
`ifdef SPI_PARITY_EN
  ,
  output logic                         parity_err
`endif
);

`ifdef SPI_PARITY_EN
  localparam int WORD_W    = DATA_W + 1;
  localparam int CTRL_ADDR = NUM_REGS - 1;
`else
  localparam int WORD_W    = DATA_W;
  localparam int CTRL_ADDR = -1;
`endif
  localparam int CNT_MAX = (ADDR_W > WORD_W) ? ADDR_W : WORD_W;
  localparam int CNT_W   = $clog2(CNT_MAX);

  // The command bit is captured on the entry edge, so IDLE leads straight to ADDR.
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                is_write;
  logic [ADDR_W-2:0]   addr_sr;
  logic [ADDR_W-1:0]   addr;
  logic [WORD_W-2:0]   data_sr;
  logic [WORD_W-2:0]   rd_sr;

  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) begin
`ifdef SPI_PARITY_EN
        if (i == CTRL_ADDR) w = DATA_W'(parity_err);
        else
`endif
        if (!WR_MASK[i])         w = status_in[i*DATA_W +: DATA_W];
        else if (i == INST_ADDR) w = '0;
        else                     w = reg_out[i*DATA_W +: DATA_W];
      end
    end
    return w;
  endfunction

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i) && (WR_MASK[i] || i == INST_ADDR || i == CTRL_ADDR)) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [WORD_W-1:0] rd_image(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = read_word(a);
`ifdef SPI_PARITY_EN
    return {w, ~^w};
`else
    return w;
`endif
  endfunction

  logic [ADDR_W-1:0] addr_full;
  logic [ADDR_W-1:0] addr_next;
  logic [WORD_W-1:0] word_full;
  logic [DATA_W-1:0] wdata;
  logic              par_ok;
  logic [WORD_W-1:0] img;

  assign addr_full = {addr_sr, pico};
  assign addr_next = (addr == ADDR_W'(NUM_REGS-1)) ? '0 : addr + ADDR_W'(1);
  assign word_full = {data_sr, pico};
  assign wdata     = word_full[WORD_W-1 -: DATA_W];
`ifdef SPI_PARITY_EN
  assign par_ok    = ^word_full;
`else
  assign par_ok    = 1'b1;
`endif
  assign img       = rd_image((state == ADDR) ? addr_full : addr_next);

  always_ff @(posedge spi_clk) begin
    wr_strobe  <= 1'b0;
    inst_pulse <= '0;
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_write <= 1'b0;
      addr_sr  <= '0;
      addr     <= '0;
      data_sr  <= '0;
      rd_sr    <= '0;
      poci     <= 1'b0;
      reg_out  <= RESET_VAL;
      wr_addr  <= '0;
`ifdef SPI_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (cs) begin
      state <= IDLE;
      cnt   <= '0;
      poci  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          is_write <= pico;
          cnt      <= '0;
          poci     <= 1'b0;
          state    <= ADDR;
        end
        ADDR: begin
          addr_sr <= addr_full[ADDR_W-2:0];
          if (cnt == CNT_W'(ADDR_W-1)) begin
            cnt   <= '0;
            addr  <= addr_full;
            state <= DATA;
            poci  <= img[WORD_W-1];
            rd_sr <= img[WORD_W-2:0];
          end else begin
            cnt  <= cnt + CNT_W'(1);
            poci <= 1'b0;
          end
        end
        DATA: begin
          data_sr <= word_full[WORD_W-2:0];
          if (cnt == CNT_W'(WORD_W-1)) begin
            cnt   <= '0;
            addr  <= addr_next;
            poci  <= img[WORD_W-1];
            rd_sr <= img[WORD_W-2:0];
            if (is_write && par_ok && writable(addr)) begin
              wr_strobe <= 1'b1;
              wr_addr   <= addr;
              if (addr == ADDR_W'(INST_ADDR)) inst_pulse <= wdata;
`ifdef SPI_PARITY_EN
              if (addr == ADDR_W'(CTRL_ADDR) && wdata[0]) parity_err <= 1'b0;
`endif
              for (int i = 0; i < NUM_REGS; i++) begin
                if (addr == ADDR_W'(i) && i != INST_ADDR && i != CTRL_ADDR)
                  reg_out[i*DATA_W +: DATA_W] <= wdata;
              end
            end
`ifdef SPI_PARITY_EN
            else if (is_write && !par_ok) parity_err <= 1'b1;
`endif
          end else begin
            cnt   <= cnt + CNT_W'(1);
            poci  <= rd_sr[WORD_W-2];
            rd_sr <= rd_sr << 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
